csi_rx_clk_lane_ctrl: RTL and testbench
=======================================

CSI_RX_CLK_LANE_CTRL -- requirements
Module: csi_rx_clk_lane_ctrl

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 16: cycles BUFR/SERDES reset is held per attempt.
REQ-002 The block SHALL have parameter SETTLE_EDGES, default 8: consecutive heartbeat edges required before release.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 64: maximum cycles between heartbeat edges before the clock counts as absent.
REQ-004 The block SHALL have parameter SERDES_DLY, default 4: cycles between settle completion and SERDES reset release.
REQ-005 The block SHALL have port clock, input, 1: free-running reference clock; all logic in this domain.
REQ-006 The block SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port enable, input, 1: high requests clock-lane bring-up; low forces shutdown.
REQ-008 The block SHALL have port heartbeat, input, 1: asynchronous toggle from the byte-clock domain, one toggle per 16 byte clocks.
REQ-009 The block SHALL have port bufr_reset, output, 1: drives CLR of the bit/byte BUFRs.
REQ-010 The block SHALL have port serdes_reset, output, 1: reset for downstream data-lane SERDES.
REQ-011 The block SHALL have port clk_locked, output, 1: clock lane running and stable.
REQ-012 The block SHALL have port loss_count, output, 8: count of clock-loss events.

Function
REQ-013 heartbeat SHALL pass through a 2-FF synchronizer plus one delay register; edge = XOR of the last two stages; toggle-to-edge latency is 3 clock cycles.
REQ-014 The FSM SHALL have states IDLE, ASSERT_RST, WAIT_EDGES, SERDES_REL, LOCKED, LOST.
REQ-015 IDLE: bufr_reset=1, serdes_reset=1, clk_locked=0; enable=1 -> ASSERT_RST.
REQ-016 ASSERT_RST: bufr_reset=1, serdes_reset=1; after exactly RST_CYCLES cycles -> WAIT_EDGES; edge and gap counters cleared on entry.
REQ-017 WAIT_EDGES: bufr_reset=0, serdes_reset=1; each edge increments the edge counter and clears the gap timer; otherwise the gap timer increments.
REQ-018 WAIT_EDGES: edge counter reaching SETTLE_EDGES -> SERDES_REL; gap timer reaching TIMEOUT_CYCLES -> ASSERT_RST (retry, no loss_count change).
REQ-019 SERDES_REL: bufr_reset=0, serdes_reset=1 for exactly SERDES_DLY cycles, then -> LOCKED.
REQ-020 LOCKED: bufr_reset=0, serdes_reset=0, clk_locked=1; gap timer runs as in WAIT_EDGES; timeout -> LOST.
REQ-021 LOST: one cycle; bufr_reset=1, serdes_reset=1, clk_locked=0; loss_count increments (saturates at 255); -> ASSERT_RST.
REQ-022 An edge and a timeout in the same cycle SHALL resolve as edge: timer cleared, no timeout.
REQ-023 enable=0 in any state SHALL take priority: next state IDLE; outputs take IDLE values from the following cycle; loss_count unchanged.
REQ-024 Gap timer and edge counter SHALL be sized from their parameters ($clog2) and SHALL NOT wrap; the gap timer holds at TIMEOUT_CYCLES.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 While reset_n=0: state IDLE, bufr_reset=1, serdes_reset=1, clk_locked=0, loss_count=0, and synchronizer, counters and timers cleared.
REQ-027 Deassertion of reset_n SHALL take effect on the next clock edge; no sequence starts until enable=1 is sampled.

Configuration
REQ-028 With macro CSI_RX_CLK_LOSS_CNT_EN defined, loss_count SHALL be implemented per REQ-021.
REQ-029 Without CSI_RX_CLK_LOSS_CNT_EN, loss_count SHALL be tied to 0, no counter logic SHALL be present, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset, enable=1, heartbeat toggling every 10 cycles -> bufr_reset low after 16 cycles; serdes_reset low 4 cycles after the 8th detected edge; clk_locked=1.
REQ-031 Locked, then heartbeat stops -> LOST 64 cycles after the last detected edge; loss_count 0->1; bufr_reset=1 for 16 cycles; relock on resumed toggling.
REQ-032 No heartbeat after enable -> repeated ASSERT_RST/WAIT_EDGES cycling (16 + 64 cycles per attempt); loss_count stays 0; clk_locked never 1.
REQ-033 enable dropped mid-WAIT_EDGES and mid-LOCKED -> IDLE next cycle; bufr_reset=1, serdes_reset=1, clk_locked=0; loss_count unchanged.
REQ-034 Edge detected in the same cycle the gap timer reaches 64 -> no timeout; 300 forced loss events -> loss_count saturates at 255; build without CSI_RX_CLK_LOSS_CNT_EN -> loss_count always 0.

Source files
------------

// File: rtl/csi_rx_clk_lane_ctrl.sv
// CSI-2 receive clock-lane bring-up sequencer and clock-loss monitor.
// Define CSI_RX_CLK_LOSS_CNT_EN to build the saturating clock-loss counter on loss_count.
module csi_rx_clk_lane_ctrl #(
    parameter int RST_CYCLES     = 16,
    parameter int SETTLE_EDGES   = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int SERDES_DLY     = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       heartbeat,
    output logic       bufr_reset,
    output logic       serdes_reset,
    output logic       clk_locked,
    output logic [7:0] loss_count
);

    localparam int RST_W  = $clog2(RST_CYCLES + 1);
    localparam int EDGE_W = $clog2(SETTLE_EDGES + 1);
    localparam int GAP_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DLY_W  = $clog2(SERDES_DLY + 1);

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(SETTLE_EDGES - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(TIMEOUT_CYCLES);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(SERDES_DLY - 1);

    typedef enum logic [2:0] {
        IDLE,
        ASSERT_RST,
        WAIT_EDGES,
        SERDES_REL,
        LOCKED,
        LOST
    } state_t;

    state_t             state_reg, state_next;
    logic [RST_W-1:0]   rst_cnt_reg, rst_cnt_next;
    logic [EDGE_W-1:0]  edge_cnt_reg, edge_cnt_next;
    logic [GAP_W-1:0]   gap_reg, gap_next, gap_inc;
    logic [DLY_W-1:0]   dly_cnt_reg, dly_cnt_next;
    logic [2:0]         hb_pipe_reg;
    logic               edge_det;
    logic               timeout;
    logic               bufr_reset_reg, bufr_reset_next;
    logic               serdes_reset_reg, serdes_reset_next;
    logic               clk_locked_reg, clk_locked_next;

    // Stages 0/1 resynchronise the byte-clock toggle; stage 2 is the delay tap for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hb_pipe_reg <= '0;
        end else begin
            hb_pipe_reg <= {hb_pipe_reg[1:0], heartbeat};
        end
    end

    assign edge_det = hb_pipe_reg[1] ^ hb_pipe_reg[2];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            rst_cnt_reg      <= '0;
            edge_cnt_reg     <= '0;
            gap_reg          <= '0;
            dly_cnt_reg      <= '0;
            bufr_reset_reg   <= 1'b1;
            serdes_reset_reg <= 1'b1;
            clk_locked_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            rst_cnt_reg      <= rst_cnt_next;
            edge_cnt_reg     <= edge_cnt_next;
            gap_reg          <= gap_next;
            dly_cnt_reg      <= dly_cnt_next;
            bufr_reset_reg   <= bufr_reset_next;
            serdes_reset_reg <= serdes_reset_next;
            clk_locked_reg   <= clk_locked_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rst_cnt_next  = rst_cnt_reg;
        edge_cnt_next = edge_cnt_reg;
        gap_next      = gap_reg;
        dly_cnt_next  = dly_cnt_reg;
        gap_inc       = (gap_reg == GAP_MAX) ? gap_reg : gap_reg + GAP_W'(1);
        // An edge in the cycle the gap would reach the limit wins over the timeout.
        timeout       = !edge_det && (gap_inc == GAP_MAX);

        unique case (state_reg)
            IDLE: begin
                rst_cnt_next  = '0;
                edge_cnt_next = '0;
                gap_next      = '0;
                dly_cnt_next  = '0;
                if (enable) begin
                    state_next = ASSERT_RST;
                end
            end
            ASSERT_RST: begin
                edge_cnt_next = '0;
                gap_next      = '0;
                if (rst_cnt_reg == RST_LAST) begin
                    state_next   = WAIT_EDGES;
                    rst_cnt_next = '0;
                end else begin
                    rst_cnt_next = rst_cnt_reg + RST_W'(1);
                end
            end
            WAIT_EDGES: begin
                gap_next = edge_det ? '0 : gap_inc;
                if (edge_det) begin
                    edge_cnt_next = edge_cnt_reg + EDGE_W'(1);
                    if (edge_cnt_reg == EDGE_LAST) begin
                        state_next   = SERDES_REL;
                        dly_cnt_next = '0;
                    end
                end else if (timeout) begin
                    state_next   = ASSERT_RST;
                    rst_cnt_next = '0;
                end
            end
            SERDES_REL: begin
                gap_next = edge_det ? '0 : gap_inc;
                if (dly_cnt_reg == DLY_LAST) begin
                    state_next   = LOCKED;
                    dly_cnt_next = '0;
                end else begin
                    dly_cnt_next = dly_cnt_reg + DLY_W'(1);
                end
            end
            LOCKED: begin
                gap_next = edge_det ? '0 : gap_inc;
                if (timeout) begin
                    state_next = LOST;
                end
            end
            LOST: begin
                state_next    = ASSERT_RST;
                rst_cnt_next  = '0;
                edge_cnt_next = '0;
                gap_next      = '0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (!enable) begin
            state_next = IDLE;
        end

        // Outputs are decoded from the next state so the registered copies track the state register.
        bufr_reset_next   = (state_next == IDLE) || (state_next == ASSERT_RST) || (state_next == LOST);
        serdes_reset_next = (state_next != LOCKED);
        clk_locked_next   = (state_next == LOCKED);
    end

    assign bufr_reset   = bufr_reset_reg;
    assign serdes_reset = serdes_reset_reg;
    assign clk_locked   = clk_locked_reg;

`ifdef CSI_RX_CLK_LOSS_CNT_EN
    logic [7:0] loss_count_reg;
    logic       loss_inc;

    assign loss_inc = (state_next == LOST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            loss_count_reg <= '0;
        end else if (loss_inc && (loss_count_reg != 8'hFF)) begin
            loss_count_reg <= loss_count_reg + 8'd1;
        end
    end

    assign loss_count = loss_count_reg;
`else
    assign loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_csi_rx_clk_lane_ctrl.sv
// Directed bench for csi_rx_clk_lane_ctrl: bring-up, loss, retry, disable, boundary and saturation.
module tb_csi_rx_clk_lane_ctrl;

    localparam int RST_CYCLES     = 16;
    localparam int SETTLE_EDGES   = 8;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int SERDES_DLY     = 4;
    localparam int HB_PER         = 10;
    // Toggle-to-consumed-edge latency is 3 cycles.
    localparam int LOCK_LAT = (SETTLE_EDGES - 1) * HB_PER + 3 + SERDES_DLY;
    localparam int LOSS_LAT = 3 + TIMEOUT_CYCLES;
`ifdef CSI_RX_CLK_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       heartbeat;
    logic       bufr_reset;
    logic       serdes_reset;
    logic       clk_locked;
    logic [7:0] loss_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hb_per   = HB_PER;
    int hb_phase = 0;
    bit hb_run   = 1'b0;
    int exp_loss = 0;

    csi_rx_clk_lane_ctrl #(
        .RST_CYCLES     (RST_CYCLES),
        .SETTLE_EDGES   (SETTLE_EDGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SERDES_DLY     (SERDES_DLY)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .heartbeat    (heartbeat),
        .bufr_reset   (bufr_reset),
        .serdes_reset (serdes_reset),
        .clk_locked   (clk_locked),
        .loss_count   (loss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // All driving and sampling happens on the falling edge, away from the active edge.
    task automatic step();
        @(negedge clock);
        cyc++;
        if (hb_run) begin
            hb_phase++;
            if (hb_phase >= hb_per) begin
                heartbeat = ~heartbeat;
                hb_phase  = 0;
            end
        end
    endtask

    task automatic start_hb(input int per);
        heartbeat = ~heartbeat;
        hb_per    = per;
        hb_phase  = 0;
        hb_run    = 1'b1;
    endtask

    task automatic note_loss();
        if (exp_loss < 255) exp_loss++;
    endtask

    function automatic logic [7:0] exp_loss_out();
        return LOSS_EN ? 8'(exp_loss) : 8'd0;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; heartbeat = 1'b0; hb_run = 1'b0;
        repeat (3) step();
        checks++; if (bufr_reset !== 1'b1) begin failures++; $display("FAIL reset_bufr got=%b exp=1", bufr_reset); end
        checks++; if (serdes_reset !== 1'b1) begin failures++; $display("FAIL reset_serdes got=%b exp=1", serdes_reset); end
        checks++; if (clk_locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", clk_locked); end
        checks++; if (loss_count !== 8'd0) begin failures++; $display("FAIL reset_loss got=%0d exp=0", loss_count); end
        enable = 1'b1;
        repeat (3) step();
        checks++; if (bufr_reset !== 1'b1) begin failures++; $display("FAIL reset_hold_enable bufr got=%b exp=1", bufr_reset); end
        enable = 1'b0; reset_n = 1'b1;
        repeat (5) step();
        checks++;
        if ({bufr_reset, serdes_reset, clk_locked} !== 3'b110) begin
            failures++; $display("FAIL reset_idle_no_enable outs=%b exp=110", {bufr_reset, serdes_reset, clk_locked});
        end
        $display("txn reset: released at cycle %0d", cyc);
    endtask

    task automatic test_lock();
        int k;
        int drops;
        bit early;
        enable = 1'b1;
        for (k = 1; k <= 100; k++) begin
            step();
            if (bufr_reset === 1'b0) break;
        end
        checks++; if (k != RST_CYCLES + 1) begin failures++; $display("FAIL lock_bufr_release cycles=%0d exp=%0d", k, RST_CYCLES + 1); end
        start_hb(HB_PER);
        early = 1'b0;
        for (k = 1; k <= 300; k++) begin
            step();
            if (clk_locked === 1'b1 && serdes_reset !== 1'b0) early = 1'b1;
            if (serdes_reset === 1'b0) break;
        end
        checks++; if (k != LOCK_LAT) begin failures++; $display("FAIL lock_serdes_release cycles=%0d exp=%0d", k, LOCK_LAT); end
        checks++; if (clk_locked !== 1'b1) begin failures++; $display("FAIL lock_locked got=%b exp=1", clk_locked); end
        checks++; if (early) begin failures++; $display("FAIL lock_early_locked got=1 exp=0"); end
        drops = 0;
        repeat (40) begin
            step();
            if (clk_locked !== 1'b1 || bufr_reset !== 1'b0) drops++;
        end
        checks++; if (drops != 0) begin failures++; $display("FAIL lock_hold drops=%0d exp=0", drops); end
        $display("txn lock: serdes released %0d cycles after first toggle", k);
    endtask

    task automatic test_loss();
        int k;
        while (hb_phase != 0) step();
        hb_run = 1'b0;
        for (k = 1; k <= 150; k++) begin
            step();
            if (clk_locked !== 1'b1) break;
        end
        note_loss();
        checks++; if (k != LOSS_LAT) begin failures++; $display("FAIL loss_detect cycles=%0d exp=%0d", k, LOSS_LAT); end
        checks++; if ({bufr_reset, serdes_reset} !== 2'b11) begin failures++; $display("FAIL loss_outs got=%b exp=11", {bufr_reset, serdes_reset}); end
        checks++; if (loss_count !== exp_loss_out()) begin failures++; $display("FAIL loss_count got=%0d exp=%0d", loss_count, exp_loss_out()); end
        for (k = 1; k <= 100; k++) begin
            step();
            if (bufr_reset === 1'b0) break;
        end
        checks++; if (k != RST_CYCLES + 1) begin failures++; $display("FAIL loss_bufr_hold cycles=%0d exp=%0d", k, RST_CYCLES + 1); end
        start_hb(HB_PER);
        for (k = 1; k <= 300; k++) begin
            step();
            if (serdes_reset === 1'b0) break;
        end
        checks++; if (k != LOCK_LAT) begin failures++; $display("FAIL loss_relock cycles=%0d exp=%0d", k, LOCK_LAT); end
        checks++; if (clk_locked !== 1'b1) begin failures++; $display("FAIL loss_relock_locked got=%b exp=1", clk_locked); end
        checks++; if (loss_count !== exp_loss_out()) begin failures++; $display("FAIL loss_count_after got=%0d exp=%0d", loss_count, exp_loss_out()); end
        $display("txn loss: loss_count=%0d relocked", loss_count);
    endtask

    task automatic test_edge_timeout();
        int k;
        int drops;
        while (hb_phase != 0) step();
        hb_per = TIMEOUT_CYCLES;
        drops = 0;
        repeat (TIMEOUT_CYCLES * 3 + 5) begin
            step();
            if (clk_locked !== 1'b1) drops++;
        end
        checks++; if (drops != 0) begin failures++; $display("FAIL edge_at_timeout drops=%0d exp=0", drops); end
        checks++; if (loss_count !== exp_loss_out()) begin failures++; $display("FAIL edge_at_timeout_loss got=%0d exp=%0d", loss_count, exp_loss_out()); end
        while (hb_phase != 0) step();
        hb_per = TIMEOUT_CYCLES + 1;
        for (k = 1; k <= 100; k++) begin
            step();
            if (clk_locked !== 1'b1) break;
        end
        hb_run = 1'b0;
        note_loss();
        checks++; if (k != LOSS_LAT) begin failures++; $display("FAIL gap_over_timeout cycles=%0d exp=%0d", k, LOSS_LAT); end
        checks++; if (loss_count !== exp_loss_out()) begin failures++; $display("FAIL gap_over_timeout_loss got=%0d exp=%0d", loss_count, exp_loss_out()); end
        $display("txn edge_timeout: boundary held, over-gap lost at %0d", k);
    endtask

    task automatic test_no_clock();
        int trans [8];
        int nt;
        bit prev;
        bit seen_lock;
        enable = 1'b0;
        repeat (3) step();
        checks++; if ({bufr_reset, serdes_reset, clk_locked} !== 3'b110) begin failures++; $display("FAIL noclk_idle outs=%b exp=110", {bufr_reset, serdes_reset, clk_locked}); end
        enable = 1'b1;
        nt = 0; prev = 1'b1; seen_lock = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (bufr_reset !== prev && nt < 8) begin
                trans[nt] = k; nt++; prev = bufr_reset;
            end
            if (clk_locked !== 1'b0) seen_lock = 1'b1;
        end
        checks++; if (nt < 4) begin failures++; $display("FAIL noclk_transitions got=%0d exp>=4", nt); end
        checks++; if (trans[0] != RST_CYCLES + 1) begin failures++; $display("FAIL noclk_fall1 got=%0d exp=%0d", trans[0], RST_CYCLES + 1); end
        checks++; if (trans[1] != RST_CYCLES + 1 + TIMEOUT_CYCLES) begin failures++; $display("FAIL noclk_rise1 got=%0d exp=%0d", trans[1], RST_CYCLES + 1 + TIMEOUT_CYCLES); end
        checks++; if (trans[2] != 2 * RST_CYCLES + 1 + TIMEOUT_CYCLES) begin failures++; $display("FAIL noclk_fall2 got=%0d exp=%0d", trans[2], 2 * RST_CYCLES + 1 + TIMEOUT_CYCLES); end
        checks++; if (trans[3] != 2 * (RST_CYCLES + TIMEOUT_CYCLES) + 1) begin failures++; $display("FAIL noclk_rise2 got=%0d exp=%0d", trans[3], 2 * (RST_CYCLES + TIMEOUT_CYCLES) + 1); end
        checks++; if (seen_lock) begin failures++; $display("FAIL noclk_locked got=1 exp=0"); end
        checks++; if (loss_count !== exp_loss_out()) begin failures++; $display("FAIL noclk_loss got=%0d exp=%0d", loss_count, exp_loss_out()); end
        $display("txn no_clock: retry transitions at %0d %0d %0d %0d", trans[0], trans[1], trans[2], trans[3]);
    endtask

    task automatic test_disable();
        int k;
        checks++; if (bufr_reset !== 1'b0) begin failures++; $display("FAIL disable_wait_pre bufr got=%b exp=0", bufr_reset); end
        enable = 1'b0;
        step();
        checks++; if ({bufr_reset, serdes_reset, clk_locked} !== 3'b110) begin failures++; $display("FAIL disable_wait outs=%b exp=110", {bufr_reset, serdes_reset, clk_locked}); end
        enable = 1'b1;
        start_hb(HB_PER);
        for (k = 1; k <= 300; k++) begin
            step();
            if (clk_locked === 1'b1) break;
        end
        checks++; if (clk_locked !== 1'b1) begin failures++; $display("FAIL disable_relock got=%b exp=1", clk_locked); end
        repeat (20) step();
        enable = 1'b0;
        step();
        checks++; if ({bufr_reset, serdes_reset, clk_locked} !== 3'b110) begin failures++; $display("FAIL disable_locked outs=%b exp=110", {bufr_reset, serdes_reset, clk_locked}); end
        checks++; if (loss_count !== exp_loss_out()) begin failures++; $display("FAIL disable_loss got=%0d exp=%0d", loss_count, exp_loss_out()); end
        repeat (10) step();
        hb_run = 1'b0;
        checks++; if ({bufr_reset, serdes_reset, clk_locked} !== 3'b110) begin failures++; $display("FAIL disable_stay_idle outs=%b exp=110", {bufr_reset, serdes_reset, clk_locked}); end
        $display("txn disable: idle from wait and from locked");
    endtask

    task automatic test_saturate();
        int k;
        enable = 1'b1;
        for (int ev = 0; ev < 300; ev++) begin
            start_hb(1);
            for (k = 1; k <= 400; k++) begin
                step();
                if (clk_locked === 1'b1) break;
            end
            if (k > 400) begin
                checks++; failures++; $display("FAIL sat_lock_timeout event=%0d got=unlocked exp=locked", ev);
                break;
            end
            hb_run = 1'b0;
            for (k = 1; k <= 200; k++) begin
                step();
                if (clk_locked !== 1'b1) break;
            end
            if (k > 200) begin
                checks++; failures++; $display("FAIL sat_loss_timeout event=%0d got=locked exp=lost", ev);
                break;
            end
            note_loss();
            checks++;
            if (loss_count !== exp_loss_out()) begin
                failures++; $display("FAIL sat_count event=%0d got=%0d exp=%0d", ev, loss_count, exp_loss_out());
            end
            $display("txn saturate: event %0d loss_count=%0d", ev, loss_count);
        end
        checks++;
        if (loss_count !== (LOSS_EN ? 8'd255 : 8'd0)) begin
            failures++; $display("FAIL sat_final got=%0d exp=%0d", loss_count, LOSS_EN ? 255 : 0);
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; heartbeat = 1'b0;
        test_reset();
        test_lock();
        test_loss();
        test_edge_timeout();
        test_no_clock();
        test_disable();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
